// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate generator behind a 2-entry elastic buffer.
// Outputs (valid, ready, head fields) all come straight from flops.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  logic [4:0]      op;
  logic [2:0]      f3;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            unused_bits;

  assign op          = in_inst[6:2];
  assign f3          = in_inst[14:12];
  assign unused_bits = &{1'b0, in_inst[1:0]};

  always_comb begin
    dec_imm = XLEN'($signed(in_inst[31:20]));
    dec_fmt = 3'd7;
    case (op)
      5'b00100: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec_fmt      = 3'd5;
          dec_imm      = '0;
          dec_imm[4:0] = in_inst[24:20];
          if (XLEN == 64) dec_imm[5] = in_inst[25];
        end else begin
          dec_fmt = 3'd0;
        end
      end
      5'b00000, 5'b11001: dec_fmt = 3'd0;
      5'b11100: begin
        if (f3[2]) begin
          dec_fmt = 3'd6;
          dec_imm = XLEN'(in_inst[19:15]);
        end else begin
          dec_fmt = 3'd0;
        end
      end
      5'b01000: begin
        dec_fmt = 3'd1;
        dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      end
      5'b11000: begin
        dec_fmt = 3'd2;
        dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      end
      5'b01101, 5'b00101: begin
        dec_fmt = 3'd3;
        dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      end
      5'b11011: begin
        dec_fmt = 3'd4;
        dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
      end
      default: ;
    endcase
  end

  logic [1:0][XLEN-1:0]  imm_mem_q, imm_mem_d;
  logic [1:0][2:0]       fmt_mem_q, fmt_mem_d;
  logic [1:0][TAG_W-1:0] tag_mem_q, tag_mem_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_imm_q, out_imm_d;
  logic [2:0]            out_fmt_q, out_fmt_d;
  logic [TAG_W-1:0]      out_tag_q, out_tag_d;
  logic                  push, pop;

  assign push = in_valid & in_ready_q & ~flush;
  assign pop  = out_valid_q & out_ready & ~flush;

  always_comb begin
    imm_mem_d = imm_mem_q;
    fmt_mem_d = fmt_mem_q;
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + 2'(push) - 2'(pop);
    if (push) begin
      imm_mem_d[wr_ptr_q] = dec_imm;
      fmt_mem_d[wr_ptr_q] = dec_fmt;
      tag_mem_d[wr_ptr_q] = in_tag;
      wr_ptr_d            = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
    in_ready_d  = (count_d != 2'd2);
    out_valid_d = (count_d != 2'd0);
    // Head registers look ahead at the next head so they stay flop outputs.
    out_imm_d   = out_valid_d ? imm_mem_d[rd_ptr_d] : '0;
    out_fmt_d   = out_valid_d ? fmt_mem_d[rd_ptr_d] : 3'd0;
    out_tag_d   = out_valid_d ? tag_mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imm_mem_q   <= '0;
      fmt_mem_q   <= '0;
      tag_mem_q   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_fmt_q   <= 3'd0;
      out_tag_q   <= '0;
    end else begin
      imm_mem_q   <= imm_mem_d;
      fmt_mem_q   <= fmt_mem_d;
      tag_mem_q   <= tag_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_fmt_q   <= out_fmt_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_fmt   = out_fmt_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus and are
// checked each cycle against a queue-based reference plus directed literals.
module tb_imm_gen_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_tag;
  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32, out_tag32, out_tag64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt32, out_fmt64;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32));

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference decode: returns {fmt, imm} with imm truncated to xl bits.
  function automatic logic [66:0] mdec(input logic [31:0] i, input int xl);
    longint     v;
    logic [2:0] f;
    logic [4:0] op;
    logic [2:0] f3;
    op = i[6:2];
    f3 = i[14:12];
    v  = longint'($signed(i[31:20]));
    f  = 3'd7;
    case (op)
      5'b00100: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          f = 3'd5;
          v = (xl == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
        end else f = 3'd0;
      end
      5'b00000, 5'b11001: f = 3'd0;
      5'b11100: begin
        if (f3[2]) begin f = 3'd6; v = longint'(i[19:15]); end
        else f = 3'd0;
      end
      5'b01000: begin f = 3'd1; v = longint'($signed({i[31:25], i[11:7]})); end
      5'b11000: begin f = 3'd2; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      5'b01101, 5'b00101: begin f = 3'd3; v = longint'($signed(i[31:12])) * 4096; end
      5'b11011: begin f = 3'd4; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      default: ;
    endcase
    if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {f, 64'(v)};
  endfunction

  typedef struct { logic [31:0] inst; logic [31:0] tag; } ent_t;
  ent_t        mq[$];
  logic [31:0] rx[$];
  bit          live = 0;

  always @(negedge clk) begin : cmp
    logic [66:0] d32, d64;
    logic [31:0] etag;
    bit          ev, pu, po;
    if (live) begin
      ev = (mq.size() != 0);
      if (ev) begin
        d32  = mdec(mq[0].inst, 32);
        d64  = mdec(mq[0].inst, 64);
        etag = mq[0].tag;
      end else begin
        d32  = '0;
        d64  = '0;
        etag = '0;
      end
      chk("out_valid32", 64'(out_valid32), 64'(ev));
      chk("out_valid64", 64'(out_valid64), 64'(ev));
      chk("in_ready32", 64'(in_ready32), 64'(mq.size() != 2));
      chk("in_ready64", 64'(in_ready64), 64'(mq.size() != 2));
      chk("out_imm32", 64'(out_imm32), d32[63:0]);
      chk("out_imm64", out_imm64, d64[63:0]);
      chk("out_fmt32", 64'(out_fmt32), 64'(d32[66:64]));
      chk("out_fmt64", 64'(out_fmt64), 64'(d64[66:64]));
      chk("out_tag32", 64'(out_tag32), 64'(etag));
      chk("out_tag64", 64'(out_tag64), 64'(etag));
      if (out_valid32 && out_ready) rx.push_back(out_tag32);
    end
    if (rst) begin
      mq.delete();
      live = 1;
    end else if (flush) begin
      mq.delete();
    end else begin
      pu = in_valid && (mq.size() != 2);
      po = (mq.size() != 0) && out_ready;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back('{in_inst, in_tag});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until the entry is accepted; returns just after the accepting edge.
  task automatic push(input logic [31:0] inst, input logic [31:0] tag);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_tag   = tag;
    do begin
      acc = in_ready32;
      cyc();
      n++;
    end while (!acc && n < 20);
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: tag %h not accepted after %0d cycles", tag, n);
    end
  endtask

  logic [31:0] tbl [8] = '{32'hFFF00093, 32'h12345037, 32'hFE000EE3, 32'h01F09093,
                           32'h3002D073, 32'hFE112C23, 32'h800000EF, 32'h43F0D093};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093;
    in_tag = 32'hBAD; out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_in_ready", 64'(in_ready64), 64'd1);
    chk("rst_imm32", 64'(out_imm32), 64'd0);
    chk("rst_imm64", out_imm64, 64'd0);
    chk("rst_fmt_tag", {29'd0, out_fmt32, out_tag32}, 64'd0);

    // T1 / T2 / T3 literal decodes
    out_ready = 1'b1;
    push(32'hFFF00093, 32'h1);
    chk("t1_valid", 64'(out_valid32), 64'd1);
    chk("t1_imm32", 64'(out_imm32), 64'h0000_0000_FFFF_FFFF);
    chk("t1_fmt", 64'(out_fmt32), 64'd0);
    chk("t1_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    push(32'h12345037, 32'h2);
    chk("t2_lui64", out_imm64, 64'h0000_0000_1234_5000);
    chk("t2_fmt", 64'(out_fmt64), 64'd3);
    push(32'h80000037, 32'h3);
    chk("t2_lui64_neg", out_imm64, 64'hFFFF_FFFF_8000_0000);
    chk("t2_lui32_neg", 64'(out_imm32), 64'h0000_0000_8000_0000);
    push(32'hFE000EE3, 32'h4);
    chk("t3_beq", 64'(out_imm32), 64'h0000_0000_FFFF_FFFC);
    chk("t3_beq_fmt", 64'(out_fmt32), 64'd2);
    push(32'h01F09093, 32'h5);
    chk("t3_slli", out_imm64, 64'd31);
    chk("t3_slli_fmt", 64'(out_fmt64), 64'd5);
    push(32'h3002D073, 32'h6);
    chk("t3_zimm", 64'(out_imm32), 64'd5);
    chk("t3_zimm_fmt", 64'(out_fmt32), 64'd6);
    push(32'h43F0D093, 32'h7);
    chk("srai_sh64", out_imm64, 64'd63);
    chk("srai_sh32", 64'(out_imm32), 64'd31);
    push(32'h800000EF, 32'h8);
    chk("jal_neg", 64'(out_imm32), 64'h0000_0000_FFF0_0000);
    chk("jal_fmt", 64'(out_fmt32), 64'd4);
    push(32'hFE112C23, 32'h9);
    push(32'h00001017, 32'hA);
    push(32'h0000000B, 32'hB);
    chk("unk_fmt", 64'(out_fmt64), 64'd7);
    cyc(); cyc();

    // T4 backpressure ordering
    out_ready = 1'b0;
    rx.delete();
    push(32'h00000013, 32'h1);
    push(32'h00000013, 32'h2);
    chk("t4_full", 64'(in_ready32), 64'd0);
    in_valid = 1'b1; in_tag = 32'h3;
    repeat (3) begin
      cyc();
      chk("t4_head_hold", 64'(out_tag32), 64'd1);
    end
    out_ready = 1'b1;
    push(32'h00000013, 32'h3);
    repeat (4) cyc();
    chk("t4_rx_count", 64'(rx.size()), 64'd3);
    if (rx.size() == 3) begin
      chk("t4_rx0", 64'(rx[0]), 64'd1);
      chk("t4_rx1", 64'(rx[1]), 64'd2);
      chk("t4_rx2", 64'(rx[2]), 64'd3);
    end

    // T5 flush while full
    out_ready = 1'b0;
    push(32'hFFF00093, 32'h10);
    push(32'hFFF00093, 32'h11);
    flush = 1'b1; in_valid = 1'b1; in_tag = 32'hDEAD;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_valid", 64'(out_valid64), 64'd0);
    chk("t5_ready", 64'(in_ready64), 64'd1);
    chk("t5_tag", 64'(out_tag64), 64'd0);
    out_ready = 1'b1;
    rx.delete();
    push(32'h00000013, 32'h12);
    cyc(); cyc();
    chk("t5_rx_count", 64'(rx.size()), 64'd1);
    if (rx.size() == 1) chk("t5_rx0", 64'(rx[0]), 64'h12);

    // T6 reset mid-operation
    out_ready = 1'b0;
    push(32'hFFF00093, 32'h20);
    rst = 1'b1; in_valid = 1'b1; in_tag = 32'h21;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_valid", 64'(out_valid32), 64'd0);
    chk("t6_ready", 64'(in_ready32), 64'd1);
    chk("t6_imm", out_imm64, 64'd0);
    chk("t6_tag", 64'(out_tag32), 64'd0);
    push(32'hFFF00093, 32'h22);
    chk("t6_post_valid", 64'(out_valid32), 64'd1);
    chk("t6_post_tag", 64'(out_tag32), 64'h22);

    // Mixed traffic, covered by the per-cycle reference compare
    repeat (300) begin
      in_valid  = ($urandom % 2) == 0;
      in_inst   = tbl[$urandom % 8];
      in_tag    = $urandom;
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 32) == 0;
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
